// File: rtl/ifu_lsu_mem_arbiter.sv
// Shares one memory port between IFU and LSU: accept -> mem_req_valid next cycle, response one cycle after mem_rsp_valid.
// One request in flight; requesters are backpressured (ready low) outside IDLE; round-robin on conflict, timeout returns error.
module ifu_lsu_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_rsp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_rsp_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_rsp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                arb_busy
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wmask;
  } mem_req_t;

  state_t            state_q, state_d;
  mem_req_t          req_q, req_d;
  logic              owner_lsu_q, last_lsu_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ifu_win, lsu_win, accept, complete, expire, in_flight;
  logic              ifu_rsp_q, lsu_rsp_q, rsp_err_q;
  logic [DATA_W-1:0] rsp_data_q;

  assign in_flight = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ifu_win  = 1'b0;
    lsu_win  = 1'b0;
    accept   = 1'b0;
    complete = 1'b0;
    expire   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rst) begin
          // LSU wins a conflict unless it was the last one served
          lsu_win = lsu_req_valid & (~ifu_req_valid | ~last_lsu_q);
          ifu_win = ifu_req_valid & ~lsu_win;
          accept  = ifu_win | lsu_win;
          if (accept) state_d = ISSUE;
        end
      end
      ISSUE: begin
        complete = mem_req_ready & mem_rsp_valid;
        if (complete)           state_d = IDLE;
        else if (mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        complete = mem_rsp_valid;
        if (complete) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // a response landing in the expiry cycle takes precedence over the error
    expire = (TIMEOUT != 0) && in_flight && !complete && (cnt_q == CNT_LAST);
    if (expire) state_d = IDLE;
  end

  always_comb begin
    req_d = '0;
    if (lsu_win) begin
      req_d.addr  = lsu_addr;
      req_d.wen   = lsu_wen;
      req_d.wdata = lsu_wdata;
      req_d.wmask = lsu_wmask;
    end else begin
      req_d.addr  = ifu_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q       <= '0;
      owner_lsu_q <= 1'b0;
      last_lsu_q  <= 1'b0;
      cnt_q       <= '0;
      ifu_rsp_q   <= 1'b0;
      lsu_rsp_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      ifu_rsp_q  <= 1'b0;
      lsu_rsp_q  <= 1'b0;
      rsp_err_q  <= 1'b0;
      rsp_data_q <= '0;
      if (accept) begin
        req_q       <= req_d;
        owner_lsu_q <= lsu_win;
        last_lsu_q  <= lsu_win;
        cnt_q       <= '0;
      end else if (in_flight && cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (complete || expire) begin
        ifu_rsp_q  <= ~owner_lsu_q;
        lsu_rsp_q  <= owner_lsu_q;
        rsp_err_q  <= expire;
        rsp_data_q <= (expire || req_q.wen) ? '0 : mem_rdata;
      end
    end
  end

  assign ifu_req_ready = ifu_win;
  assign lsu_req_ready = lsu_win;
  assign mem_req_valid = (state_q == ISSUE);
  assign mem_addr      = req_q.addr;
  assign mem_wen       = req_q.wen;
  assign mem_wdata     = req_q.wdata;
  assign mem_wmask     = req_q.wmask;
  assign arb_busy      = in_flight;

  assign ifu_rsp_valid = ifu_rsp_q;
  assign ifu_rsp_err   = ifu_rsp_q & rsp_err_q;
  assign ifu_rdata     = ifu_rsp_q ? rsp_data_q : '0;
  assign lsu_rsp_valid = lsu_rsp_q;
  assign lsu_rsp_err   = lsu_rsp_q & rsp_err_q;
  assign lsu_rdata     = lsu_rsp_q ? rsp_data_q : '0;

endmodule

// File: tb/tb_ifu_lsu_mem_arbiter.sv
// Randomized bench for ifu_lsu_mem_arbiter with a transaction-level reference model.
module tb_ifu_lsu_mem_arbiter;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_rsp_valid, ifu_rsp_err;
  logic [63:0] ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [63:0] lsu_wdata;
  logic [7:0]  lsu_wmask;
  logic        lsu_rsp_valid, lsu_rsp_err;
  logic [63:0] lsu_rdata;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [63:0] mem_rdata;
  logic        arb_busy;

  ifu_lsu_mem_arbiter #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata), .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata), .lsu_rsp_err(lsu_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit last_lsu;
  bit ifu_pend, lsu_pend;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ifu_rsp"}, 64'(ifu_rsp_valid), 64'd0);
    chk({tag, "_lsu_rsp"}, 64'(lsu_rsp_valid), 64'd0);
    chk({tag, "_ifu_rdata"}, ifu_rdata, 64'd0);
    chk({tag, "_lsu_rdata"}, lsu_rdata, 64'd0);
    chk({tag, "_errs"}, 64'({ifu_rsp_err, lsu_rsp_err}), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_ifu_ready", 64'(ifu_req_ready), 64'd0);
    chk("rst_lsu_ready", 64'(lsu_req_ready), 64'd0);
    chk("rst_busy", 64'(arb_busy), 64'd0);
    chk("rst_mem_vld", 64'(mem_req_valid), 64'd0);
    chk("rst_mem_fields", {mem_addr, 23'd0, mem_wen, mem_wmask}, 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    chk_quiet("rst");
    rst = 1'b0;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    ifu_pend = 1'b0;
    lsu_pend = 1'b0;
    last_lsu = 1'b0;
  endtask

  // Caller is just past a negedge with pending requests driven; the DUT is idle.
  // rd = ISSUE cycles before memory ready; rs = cycles from ready to response.
  task automatic run_txn(input int rd, input int rs, input logic [63:0] rdat, output bit won_lsu);
    logic [31:0] ea;
    logic        ew;
    logic [63:0] ewd;
    logic [7:0]  ewm;
    int          kc, kend;
    bit          tmo;
    #1;
    won_lsu = (ifu_pend && lsu_pend) ? !last_lsu : lsu_pend;
    chk("ifu_ready", 64'(ifu_req_ready), 64'(!won_lsu));
    chk("lsu_ready", 64'(lsu_req_ready), 64'(won_lsu));
    chk("busy_idle", 64'(arb_busy), 64'd0);
    ea  = won_lsu ? lsu_addr : ifu_addr;
    ew  = won_lsu ? lsu_wen : 1'b0;
    ewd = won_lsu ? lsu_wdata : 64'd0;
    ewm = won_lsu ? lsu_wmask : 8'd0;
    last_lsu = won_lsu;
    @(posedge clk);
    @(negedge clk);
    if (won_lsu) begin lsu_pend = 1'b0; lsu_req_valid = 1'b0; end
    else         begin ifu_pend = 1'b0; ifu_req_valid = 1'b0; end
    kc   = rd + 1 + rs;
    tmo  = (kc > TMO);
    kend = tmo ? TMO : kc;
    for (int k = 1; k <= kend; k++) begin
      mem_req_ready = (k == rd + 1);
      mem_rsp_valid = (k == kc);
      mem_rdata     = (k == kc) ? rdat : {$urandom, $urandom};
      #1;
      chk("mem_vld", 64'(mem_req_valid), 64'(k <= rd + 1));
      if (k <= rd + 1) begin
        chk("mem_addr", 64'(mem_addr), 64'(ea));
        chk("mem_wen", 64'(mem_wen), 64'(ew));
        chk("mem_wdata", mem_wdata, ewd);
        chk("mem_wmask", 64'(mem_wmask), 64'(ewm));
      end
      chk("busy", 64'(arb_busy), 64'd1);
      chk("ready_busy", 64'({ifu_req_ready, lsu_req_ready}), 64'd0);
      chk_quiet("inflight");
      @(posedge clk);
      @(negedge clk);
    end
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    #1;
    chk("ifu_rsp_vld", 64'(ifu_rsp_valid), 64'(!won_lsu));
    chk("lsu_rsp_vld", 64'(lsu_rsp_valid), 64'(won_lsu));
    chk("ifu_rsp_err", 64'(ifu_rsp_err), 64'(!won_lsu && tmo));
    chk("lsu_rsp_err", 64'(lsu_rsp_err), 64'(won_lsu && tmo));
    chk("ifu_rdata", ifu_rdata, (!won_lsu && !tmo) ? rdat : 64'd0);
    chk("lsu_rdata", lsu_rdata, (won_lsu && !tmo && !ew) ? rdat : 64'd0);
    chk("busy_done", 64'(arb_busy), 64'd0);
    chk("mem_vld_done", 64'(mem_req_valid), 64'd0);
  endtask

  task automatic new_reqs();
    if (!ifu_pend && ($urandom_range(0, 1) == 1)) begin
      ifu_pend = 1'b1;
      ifu_addr = $urandom;
    end
    if (!lsu_pend && ($urandom_range(0, 1) == 1 || !ifu_pend)) begin
      lsu_pend  = 1'b1;
      lsu_addr  = $urandom;
      lsu_wen   = 1'($urandom);
      lsu_wdata = {$urandom, $urandom};
      lsu_wmask = 8'($urandom);
    end
    ifu_req_valid = ifu_pend;
    lsu_req_valid = lsu_pend;
  endtask

  initial begin
    bit won;
    rst = 1'b1;
    ifu_req_valid = 1'b0; ifu_addr = '0;
    lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
    do_reset();

    // IFU fetch: ready at N+1, response at N+2
    ifu_pend = 1'b1; ifu_addr = 32'h8000_0000; ifu_req_valid = 1'b1;
    run_txn(0, 1, 64'h0000_0013_0000_0093, won);

    // LSU store
    lsu_pend = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
    lsu_wdata = 64'hDEAD_BEEF; lsu_wmask = 8'h0F; lsu_req_valid = 1'b1;
    run_txn(0, 0, 64'h1234_5678_9ABC_DEF0, won);

    // Timeout: memory never ready
    ifu_pend = 1'b1; ifu_addr = 32'h8000_0040; ifu_req_valid = 1'b1;
    run_txn(100, 0, 64'h0, won);

    // Stray response while idle
    mem_rsp_valid = 1'b1; mem_rdata = 64'h55;
    #1 chk("stray_busy", 64'(arb_busy), 64'd0);
    @(posedge clk); @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1 chk_quiet("stray");

    // Both requesters contend from reset
    do_reset();
    for (int i = 0; i < 6; i++) begin
      ifu_pend = 1'b1; lsu_pend = 1'b1;
      ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
      if (i == 0) begin ifu_addr = 32'h100; lsu_addr = 32'h200; lsu_wen = 1'b0; end
      run_txn(0, 0, {$urandom, $urandom}, won);
      chk("grant_seq", 64'(won), 64'(i % 2 == 0));
    end

    // Reset during WAIT
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; ifu_pend = 1'b0; lsu_pend = 1'b0;
    @(negedge clk);
    ifu_addr = 32'h8000_0100; ifu_req_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    #1 chk("rstwait_issue", 64'(mem_req_valid), 64'd1);
    @(posedge clk); @(negedge clk);
    mem_req_ready = 1'b0;
    #1 chk("rstwait_wait", 64'({arb_busy, mem_req_valid}), 64'b10);
    rst = 1'b1; mem_rsp_valid = 1'b1; mem_rdata = 64'h77;
    @(posedge clk); @(negedge clk);
    #1;
    chk("rstwait_busy", 64'(arb_busy), 64'd0);
    chk("rstwait_mem", {mem_addr, 23'd0, mem_req_valid, mem_wmask}, 64'd0);
    chk_quiet("rstwait");
    rst = 1'b0; last_lsu = 1'b0;
    @(posedge clk); @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1 chk_quiet("rstwait_late");
    ifu_pend = 1'b1; ifu_addr = 32'h8000_0200; ifu_req_valid = 1'b1;
    run_txn(1, 1, 64'hCAFE_F00D_0000_0001, won);

    // Randomized traffic with varied memory latency (some time out)
    for (int i = 0; i < 60; i++) begin
      new_reqs();
      run_txn($urandom_range(0, 4), $urandom_range(0, 2), {$urandom, $urandom}, won);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
